// File: rtl/sort_three_floats_seq.sv
// sort_three_floats_seq: sorts three FP64 operands with one time-shared comparator (3-pass bubble).
// Optional SORT_SEQ_EARLY_ERR_EN: a NaN compare jumps straight to DONE.
package sort_three_floats_seq_pkg;
  localparam int FLEN = 64;
endpackage

module f_less_or_equal
  import sort_three_floats_seq_pkg::*;
(
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);
  logic a_nan, b_nan, both_zero;
  always_comb begin
    a_nan = &a[62:52] && |a[51:0];
    b_nan = &b[62:52] && |b[51:0];
    both_zero = ~|{a[62:0], b[62:0]};
    err = a_nan | b_nan;
    // NaN reports "in order" so that no swap happens on an unordered compare
    res = err ? 1'b1 :
          both_zero ? 1'b1 :
          (a[63] != b[63]) ? a[63] :
          a[63] ? (a[62:0] >= b[62:0]) : (a[62:0] <= b[62:0]);
  end
endmodule

module sort_three_floats_seq
  import sort_three_floats_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [0:2][FLEN-1:0]  unsorted,
  output logic                  down_valid,
  input  logic                  down_ready,
  output logic [0:2][FLEN-1:0]  sorted,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, CMP01, CMP12, CMP01B, DONE} state_t;
  state_t state, state_next;
  logic [0:2][FLEN-1:0] w;
  logic [FLEN-1:0] a, b;
  logic err_r, le, le_err, cmp, abort, swap;

  f_less_or_equal u_cmp (.a(a), .b(b), .res(le), .err(le_err));

  always_comb begin
    cmp = (state == CMP01) || (state == CMP12) || (state == CMP01B);
    a = (state == CMP12) ? w[1] : w[0];
    b = (state == CMP12) ? w[2] : w[1];
`ifdef SORT_SEQ_EARLY_ERR_EN
    abort = cmp && le_err;
`else
    abort = 1'b0;
`endif
    swap = cmp && !le && !abort;
    state_next = (state == IDLE)   ? (up_valid ? CMP01 : IDLE) :
                 (state == CMP01)  ? (abort ? DONE : CMP12) :
                 (state == CMP12)  ? (abort ? DONE : CMP01B) :
                 (state == CMP01B) ? DONE :
                 (down_ready ? IDLE : DONE);
    up_ready = state == IDLE;
    down_valid = state == DONE;
    sorted = w;
    err = err_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      w <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_next;
      if (up_ready && up_valid) begin
        w <= unsorted;
        err_r <= 1'b0;
      end else if (cmp) begin
        err_r <= err_r | le_err;
        if (swap && state == CMP12) begin
          w[1] <= w[2];
          w[2] <= w[1];
        end else if (swap) begin
          w[0] <= w[1];
          w[1] <= w[0];
        end
      end
    end
  end
endmodule

// File: tb/tb_sort_three_floats_seq.sv
// tb_sort_three_floats_seq: randomized and directed checks against a real-valued stable-sort model.
module tb_sort_three_floats_seq;
  logic clk = 0;
  logic rst, up_valid, up_ready, down_valid, down_ready, err;
  logic [0:2][63:0] unsorted, sorted;
  int errors = 0, checks = 0;

  localparam logic [63:0] P1 = 64'h3FF0000000000000, P2 = 64'h4000000000000000,
                          P3 = 64'h4008000000000000, M1 = 64'hBFF0000000000000,
                          NZ = 64'h8000000000000000, PZ = 64'h0000000000000000,
                          QN = 64'h7FF8000000000000;
`ifdef SORT_SEQ_EARLY_ERR_EN
  localparam int NAN1_LAT = 2;
`else
  localparam int NAN1_LAT = 4;
`endif

  sort_three_floats_seq dut (.clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
    .unsorted(unsorted), .down_valid(down_valid), .down_ready(down_ready), .sorted(sorted), .err(err));

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [63:0] x);
    return x[62:52] == 11'h7FF && x[51:0] != 0;
  endfunction

  // stable insertion sort on numeric value
  function automatic logic [0:2][63:0] ref_sort(input logic [0:2][63:0] u);
    logic [0:2][63:0] r;
    logic [63:0] t;
    r = u;
    for (int i = 1; i < 3; i++)
      for (int j = i; j > 0 && $bitstoreal(r[j]) < $bitstoreal(r[j-1]); j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    return r;
  endfunction

  function automatic logic [63:0] rnd_val();
    logic [63:0] x;
    case ($urandom_range(0, 5))
      0: x = $urandom_range(0, 1) ? NZ : PZ;
      1: x = $urandom_range(0, 1) ? P1 : M1;
      default: begin
        x = {$urandom, $urandom};
        if (x[62:52] == 11'h7FF) x[62] = 1'b0;
      end
    endcase
    return x;
  endfunction

  task automatic xfer(input logic [0:2][63:0] u, output logic [0:2][63:0] s,
                      output logic e, output int lat);
    @(negedge clk);
    unsorted = u; up_valid = 1; down_ready = 0;
    @(posedge clk); #1;
    up_valid = 0; unsorted = {6{$urandom}};
    lat = 1;
    while (!down_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    s = sorted; e = err;
    @(negedge clk) down_ready = 1;
    @(posedge clk); #1 down_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; up_valid = 1; down_ready = 0; unsorted = {P3, P2, P1};
    #1;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready got=%b exp=1", up_ready); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid got=%b exp=0", down_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (sorted !== '0) begin errors++; $display("FAIL reset_sorted got=%h exp=0", sorted); end
    repeat (2) @(posedge clk);
    #1 checks++; if (up_ready !== 1'b1 || sorted !== '0) begin errors++; $display("FAIL reset_hold got=%b/%h exp=1/0", up_ready, sorted); end
    @(negedge clk); rst = 1; up_valid = 0;
  endtask

  task automatic test_directed();
    logic [0:2][63:0] vec [5] = '{{P3, P1, P2}, {P3, P2, M1}, {P1, P2, P3}, {NZ, PZ, P1}, {P2, P2, P1}};
    logic [0:2][63:0] s;
    logic e;
    int lat;
    for (int i = 0; i < 5; i++) begin
      xfer(vec[i], s, e, lat);
      checks++; if (s !== ref_sort(vec[i])) begin errors++; $display("FAIL dir%0d_sorted got=%h exp=%h", i, s, ref_sort(vec[i])); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL dir%0d_err got=%b exp=0", i, e); end
      checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
    end
    xfer({P3, P1, P2}, s, e, lat);
    checks++; if (s !== {P1, P2, P3}) begin errors++; $display("FAIL dir_const got=%h exp=%h", s, {P1, P2, P3}); end
    xfer({NZ, PZ, P1}, s, e, lat);
    checks++; if (s !== {NZ, PZ, P1}) begin errors++; $display("FAIL dir_zero_stable got=%h exp=%h", s, {NZ, PZ, P1}); end
  endtask

  task automatic test_nan();
    logic [0:2][63:0] s;
    logic e;
    int lat;
    xfer({P1, QN, P2}, s, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL nan_err got=%b exp=1", e); end
    checks++; if (lat != NAN1_LAT) begin errors++; $display("FAIL nan_latency got=%0d exp=%0d", lat, NAN1_LAT); end
    xfer({P3, P1, P2}, s, e, lat);
    checks++; if (e !== 1'b0 || s !== {P1, P2, P3}) begin errors++; $display("FAIL nan_clear got=%b/%h exp=0/%h", e, s, {P1, P2, P3}); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk); unsorted = {P3, P1, P2}; up_valid = 1; down_ready = 0;
    @(posedge clk); #1 up_valid = 0;
    while (!down_valid && n < 12) begin @(posedge clk); #1; n++; end
    checks++; if (!down_valid) begin errors++; $display("FAIL bp_timeout got=%b exp=1", down_valid); end
    @(negedge clk); up_valid = 1; unsorted = {M1, M1, M1};
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (down_valid !== 1'b1 || sorted !== {P1, P2, P3} || err !== 1'b0 || up_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got=v%b r%b e%b %h exp=v1 r0 e0 %h", down_valid, up_ready, err, sorted, {P1, P2, P3});
      end
    end
    @(negedge clk); up_valid = 0; down_ready = 1;
    @(posedge clk); #1;
    checks++; if (down_valid !== 1'b0 || up_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", down_valid, up_ready); end
    down_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [0:2][63:0] s;
    logic e;
    int lat;
    @(negedge clk); unsorted = {P3, P2, P1}; up_valid = 1;
    @(posedge clk); #1 up_valid = 0;
    @(posedge clk); #1 rst = 0;
    #1;
    checks++; if (down_valid !== 1'b0 || up_ready !== 1'b1 || sorted !== '0) begin errors++; $display("FAIL midrst got=v%b r%b %h exp=v0 r1 0", down_valid, up_ready, sorted); end
    @(negedge clk); rst = 1;
    xfer({P2, P1, P3}, s, e, lat);
    checks++; if (s !== {P1, P2, P3} || e !== 1'b0 || lat != 4) begin errors++; $display("FAIL midrst_after got=%h e%b l%0d exp=%h e0 l4", s, e, lat, {P1, P2, P3}); end
  endtask

  task automatic test_random();
    logic [0:2][63:0] u, s;
    logic e, en;
    int lat;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 3; i++) u[i] = rnd_val();
      if ($urandom_range(0, 7) == 0) u[$urandom_range(0, 2)] = {$urandom_range(0, 1) == 1, 11'h7FF, 20'h80000 | 20'($urandom), 32'($urandom)};
      en = is_nan(u[0]) || is_nan(u[1]) || is_nan(u[2]);
      xfer(u, s, e, lat);
      checks++; if (e !== en) begin errors++; $display("FAIL rnd%0d_err got=%b exp=%b", k, e, en); end
      if (!en) begin
        checks++; if (s !== ref_sort(u)) begin errors++; $display("FAIL rnd%0d_sorted got=%h exp=%h", k, s, ref_sort(u)); end
        checks++; if (lat != 4) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=4", k, lat); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int results = 0;
    @(negedge clk); unsorted = {P2, P3, P1}; up_valid = 1; down_ready = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (down_valid) begin
        results++;
        checks++; if (sorted !== {P1, P2, P3}) begin errors++; $display("FAIL b2b_sorted got=%h exp=%h", sorted, {P1, P2, P3}); end
      end
    end
    checks++; if (results != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", results); end
    @(negedge clk); up_valid = 0;
    @(negedge clk); down_ready = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_nan();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
